// File: rtl/jam_cost_scheduler_if.sv
// Requester / cost-table side bundle of the permutation cost scheduler.
// The slave modport is the scheduler; the master modport is the requesters plus the table.
interface jam_cost_scheduler_if #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned ID_BITS = 1
);
   logic [NREQ-1:0]      req;
   logic [NREQ*24-1:0]   perm;
   logic [NREQ-1:0]      gnt;
   logic [2:0]           W;
   logic [2:0]           J;
   logic [6:0]           Cost;
   logic                 done;
   logic [ID_BITS-1:0]   done_id;
   logic [9:0]           done_sum;

   modport master (
      output req, perm, Cost,
      input  gnt, W, J, done, done_id, done_sum
   );

   modport slave (
      input  req, perm, Cost,
      output gnt, W, J, done, done_id, done_sum
   );
endinterface

// File: rtl/jam_cost_scheduler.sv
// Round-robin time-sharing of one cost-table read port among NREQ permutation evaluators;
// walks workers 0..7 of the granted assignment and reports the summed cost with a done pulse.
module jam_cost_scheduler #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned ID_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   jam_cost_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [ID_BITS-1:0]   last_id_q, last_id_d;
   logic [ID_BITS-1:0]   done_id_q, done_id_d;
   logic [23:0]          perm_q, perm_d;
   logic [9:0]           sum_q, sum_d;
   logic [9:0]           done_sum_q, done_sum_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;

   logic                 found;
   int unsigned          sel_idx;
   int unsigned          cand;
   logic [2:0]           w_o, j_o;

   // First pending requester searching upward from the one after last_id, with wrap.
   always_comb begin
      found   = 1'b0;
      sel_idx = 0;
      cand    = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = (32'(last_id_q) + i) % NREQ;
         if (!found && (|(bus.req & (NREQ'(1) << cand)))) begin
            found   = 1'b1;
            sel_idx = cand;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_id_q  <= ID_BITS'(NREQ - 1);
         done_id_q  <= '0;
         perm_q     <= '0;
         sum_q      <= '0;
         done_sum_q <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_id_q  <= last_id_d;
         done_id_q  <= done_id_d;
         perm_q     <= perm_d;
         sum_q      <= sum_d;
         done_sum_q <= done_sum_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_id_d  = last_id_q;
      done_id_d  = done_id_q;
      perm_d     = perm_q;
      sum_d      = sum_q;
      done_sum_d = done_sum_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               state_d   = EVAL;
               gnt_d     = NREQ'(1) << sel_idx;
               last_id_d = ID_BITS'(sel_idx);
               perm_d    = 24'(bus.perm >> (24 * sel_idx));
               sum_d     = '0;
               cnt_d     = '0;
            end
         end
         EVAL: begin
            sum_d = sum_q + 10'(bus.Cost);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d    = DONE;
               gnt_d      = '0;
               done_d     = 1'b1;
               done_id_d  = last_id_q;
               done_sum_d = sum_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      w_o = '0;
      j_o = '0;
      if (state_q == EVAL) begin
         w_o = cnt_q;
         j_o = 3'(perm_q >> (32'(cnt_q) * 3));
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.W        = w_o;
   assign bus.J        = j_o;
   assign bus.done     = done_q;
   assign bus.done_id  = done_id_q;
   assign bus.done_sum = done_sum_q;

endmodule

// File: tb/tb_jam_cost_scheduler.sv
// Scoreboard bench for jam_cost_scheduler: a transaction-level predictor queues expected
// completions as stimulus is driven; an independent monitor checks every cycle.
module tb_jam_cost_scheduler;
   localparam int unsigned NREQ    = 2;
   localparam int unsigned ID_BITS = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jam_cost_scheduler_if #(.NREQ(NREQ), .ID_BITS(ID_BITS)) bus ();

   jam_cost_scheduler #(.NREQ(NREQ), .ID_BITS(ID_BITS)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   logic [6:0] tbl [0:7][0:7];
   always_comb bus.Cost = tbl[bus.W][bus.J];

   typedef struct {
      int id;
      int sum;
      int de;
   } exp_t;

   exp_t            exp_q[$];
   int              checks = 0;
   int              errors = 0;
   int              cyc    = 0;

   // Predictor state: grant window, fairness pointer, earliest next grant edge.
   int              last_m    = NREQ - 1;
   int              next_free = 0;
   bit              g_active  = 1'b0;
   int              g_start   = 0;
   int              g_id      = 0;
   logic [23:0]     g_perm    = '0;
   bit [NREQ-1:0]   granted_m = '0;
   bit [NREQ-1:0]   waiting   = '0;
   int              done_edge_m [NREQ];
   logic [23:0]     cur_perm    [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] mk_perm(input bit rev);
      logic [23:0] v;
      v = '0;
      for (int w = 0; w < 8; w++) v[3*w +: 3] = rev ? 3'(7 - w) : 3'(w);
      return v;
   endfunction

   function automatic logic [23:0] rand_perm();
      logic [23:0] v;
      v = '0;
      for (int w = 0; w < 8; w++) v[3*w +: 3] = 3'($urandom_range(0, 7));
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic set_table(input int mode);
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++)
            tbl[w][j] = (mode == 0) ? 7'(8 * w + j) :
                        (mode == 1) ? 7'd127 : 7'($urandom_range(0, 127));
   endtask

   // Drive one edge's worth of inputs and predict what the scheduler does with them.
   task automatic drive(input logic rst_v, input logic [NREQ-1:0] r, input logic [NREQ*24-1:0] p);
      int          n, pick, s;
      bit          fnd;
      logic [23:0] sp;
      rst_n    = rst_v;
      bus.req  = r;
      bus.perm = p;
      n = cyc + 1;
      if (!rst_v) begin
         exp_q.delete();
         g_active  = 1'b0;
         next_free = n + 1;
         last_m    = NREQ - 1;
         granted_m = '0;
         waiting   = '0;
      end else if (n >= next_free && r != '0) begin
         fnd  = 1'b0;
         pick = 0;
         for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (last_m + i) % NREQ;
            if (!fnd && r[c]) begin
               fnd  = 1'b1;
               pick = c;
            end
         end
         sp = p[pick*24 +: 24];
         s  = 0;
         for (int w = 0; w < 8; w++) s += int'(tbl[w][sp[3*w +: 3]]);
         exp_q.push_back('{pick, s, n + 8});
         g_active          = 1'b1;
         g_start           = n;
         g_id              = pick;
         g_perm            = sp;
         next_free         = n + 10;
         last_m            = pick;
         granted_m[pick]   = 1'b1;
         waiting[pick]     = 1'b0;
         done_edge_m[pick] = n + 8;
      end
   endtask

   task automatic tick(input logic rst_v, input logic [NREQ-1:0] r, input logic [NREQ*24-1:0] p);
      @(negedge clk);
      drive(rst_v, r, p);
   endtask

   task automatic rand_tick();
      logic [NREQ-1:0]      r;
      logic [NREQ*24-1:0]   p;
      @(negedge clk);
      r = '0;
      p = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (granted_m[i]) begin
            if (cyc >= done_edge_m[i]) begin
               granted_m[i] = 1'b0;
               waiting[i]   = ($urandom_range(0, 1) == 1);
               cur_perm[i]  = rand_perm();
               r[i]         = waiting[i];
            end else begin
               r[i] = ($urandom_range(0, 2) != 0);
               if ($urandom_range(0, 3) == 0) cur_perm[i] = rand_perm();
            end
         end else begin
            if (!waiting[i] && $urandom_range(0, 3) == 0) begin
               waiting[i]  = 1'b1;
               cur_perm[i] = rand_perm();
            end
            r[i] = waiting[i];
         end
         p[i*24 +: 24] = cur_perm[i];
      end
      drive(1'b1, r, p);
   endtask

   // Monitor: sample 1 time unit after each rising edge.
   initial begin
      logic r_s;
      bit   inw, exp_now;
      int   c, hold_sum;
      exp_t e;
      hold_sum = 0;
      forever begin
         @(posedge clk);
         r_s = rst_n;
         #1;
         c = cyc;
         if (!r_s) hold_sum = 0;
         inw = g_active && (c >= g_start) && (c <= g_start + 7);
         chk("gnt", int'(bus.gnt), inw ? (1 << g_id) : 0);
         chk("W", int'(bus.W), inw ? (c - g_start) : 0);
         chk("J", int'(bus.J), inw ? int'(g_perm[3*(c - g_start) +: 3]) : 0);
         exp_now = (exp_q.size() > 0) && (exp_q[0].de == c);
         chk("done", int'(bus.done), int'(exp_now));
         if (exp_now) begin
            e = exp_q.pop_front();
            chk("done_id", int'(bus.done_id), e.id);
            chk("done_sum", int'(bus.done_sum), e.sum);
            hold_sum = e.sum;
         end else begin
            chk("done_sum_hold", int'(bus.done_sum), hold_sum);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] p_a;
      bus.req  = '0;
      bus.perm = '0;
      for (int i = 0; i < NREQ; i++) begin
         done_edge_m[i] = 0;
         cur_perm[i]    = '0;
      end
      set_table(0);
      repeat (3) tick(1'b0, '0, '0);

      // Single requester, identity assignment on the 8W+J table.
      repeat (9) tick(1'b1, 2'b01, {24'b0, mk_perm(1'b0)});
      repeat (4) tick(1'b1, 2'b00, '0);

      // Both requesters held from reset: alternating service.
      repeat (2) tick(1'b0, '0, '0);
      repeat (40) tick(1'b1, 2'b11, {rand_perm(), rand_perm()});
      repeat (12) tick(1'b1, 2'b00, '0);

      // Requester 1 drops req while its evaluation is in flight.
      set_table(2);
      p_a = rand_perm();
      repeat (4) tick(1'b1, 2'b10, {p_a, 24'b0});
      repeat (12) tick(1'b1, 2'b00, '0);

      // Maximum-cost table.
      set_table(1);
      repeat (30) tick(1'b1, 2'b11, {rand_perm(), rand_perm()});
      repeat (12) tick(1'b1, 2'b00, '0);

      // Assignment changed right after grant must not be seen.
      set_table(2);
      tick(1'b1, 2'b01, {24'b0, mk_perm(1'b0)});
      repeat (8) tick(1'b1, 2'b01, {24'b0, mk_perm(1'b1)});
      repeat (12) tick(1'b1, 2'b00, '0);

      // Reset during EVAL with counter at 4, then both requesting.
      repeat (5) tick(1'b1, 2'b01, {rand_perm(), rand_perm()});
      tick(1'b0, 2'b00, '0);
      repeat (25) tick(1'b1, 2'b11, {rand_perm(), rand_perm()});
      repeat (12) tick(1'b1, 2'b00, '0);

      // Randomised requesters.
      set_table(2);
      waiting   = '0;
      granted_m = '0;
      repeat (400) rand_tick();
      repeat (14) tick(1'b1, 2'b00, '0);

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
